player_ctrl: RTL and testbench
==============================

PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 LIVES_INIT, 3, lives loaded at game start (1..3).
REQ-002 HIT_FRAMES, 30, frames movement is frozen after a hit.
REQ-003 INVULN_FRAMES, 60, frames of hit immunity after respawn.
REQ-004 BLINK_FRAMES, 4, frames per visibility toggle during immunity.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-clk pulse per video frame.
REQ-008 leftKey / rightKey  in  1 each  raw held-key levels.
REQ-009 leftCrash / rightCrash  in  1 each  character touching left/right obstacle.
REQ-010 ballHit  in  1  character/ball collision level.
REQ-011 gameStart  in  1  one-clk start request.
REQ-012 leftPress / rightPress  out  1 each  arbitrated move requests to the character mover.
REQ-013 moverResetN  out  1  active-low one-clk pulse returning the mover to its start position.
REQ-014 charVisible  out  1  character draw enable.
REQ-015 lives  out  2  remaining lives.
REQ-016 gameOver  out  1  high in GAME_OVER.

Function
REQ-017 FSM states SHALL be IDLE, PLAY, HIT, RESPAWN, GAME_OVER; all outputs registered.
REQ-018 IDLE: gameStart -> RESPAWN; lives loaded with LIVES_INIT on that edge.
REQ-019 PLAY: ballHit with immunity counter zero -> HIT, lives decremented by 1 on the same edge, saturating at 0.
REQ-020 HIT: frame counter counts startOfFrame pulses; after HIT_FRAMES pulses -> GAME_OVER if lives==0, else RESPAWN.
REQ-021 RESPAWN: moverResetN low for exactly one clk, then PLAY with immunity counter = INVULN_FRAMES.
REQ-022 GAME_OVER: gameOver=1; gameStart -> RESPAWN with lives reloaded.
REQ-023 Immunity counter SHALL decrement on each startOfFrame in PLAY, stopping at 0; ballHit ignored while nonzero.
REQ-024 leftPress/rightPress SHALL be 0 in every state except PLAY and SHALL never both be 1.
REQ-025 In PLAY, one key held -> that direction; both held -> the most recently pressed key wins; simultaneous 0->1 on both -> neither.
REQ-026 A direction SHALL be suppressed while its matching crash input is high; the other key SHALL NOT take over.
REQ-027 Press outputs SHALL follow key changes with one clk latency.
REQ-028 charVisible=1 except during immunity blinking (REQ-032); charVisible=1 in HIT.
REQ-029 gameStart outside IDLE/GAME_OVER SHALL be ignored.

Reset
REQ-030 On resetN low: state IDLE, lives=0, counters 0, leftPress=rightPress=0, moverResetN=1, charVisible=1, gameOver=0; last-press memory cleared.
REQ-031 Reset mid-hit or mid-respawn SHALL abandon the sequence with no moverResetN pulse emitted.

Configuration
REQ-032 With PLAYER_CTRL_BLINK_EN defined, charVisible toggles every BLINK_FRAMES frames while immunity counter is nonzero, starting at 0 on entry to PLAY, and is forced 1 when the counter reaches 0; without it charVisible stays 1 and immunity is unchanged.

Structure
REQ-033 Package player_ctrl_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 Sub-module key_arbiter SHALL implement REQ-025..REQ-027 (last-press priority plus crash masking), enabled by a PLAY input.

Verification
REQ-035 Reset, gameStart pulse -> moverResetN low 1 clk, lives=3, state PLAY, immunity=60.
REQ-036 PLAY, rightKey held, leftKey pressed 10 clk later -> rightPress then leftPress only; release leftKey -> rightPress=1.
REQ-037 rightKey held with rightCrash=1 -> rightPress=0, leftPress=0; drop crash -> rightPress=1 next clk.
REQ-038 ballHit during immunity -> no state change; ballHit after 60 frames -> HIT, lives 3->2, presses 0 for 30 frames, then moverResetN pulse.
REQ-039 Three hits -> lives=0, GAME_OVER, gameOver=1; gameStart -> lives=3, RESPAWN.
REQ-040 With PLAYER_CTRL_BLINK_EN, charVisible toggles every 4 frames for 60 frames then stays 1; without it stays 1.

Source files
------------

// File: rtl/player_ctrl_pkg.sv
// Shared types and default tuning constants for the player controller.
package player_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_HIT,
        ST_RESPAWN,
        ST_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_LEFT,
        LAST_RIGHT
    } last_key_t;

    localparam int DEF_LIVES_INIT    = 3;
    localparam int DEF_HIT_FRAMES    = 30;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES  = 4;

endpackage

// File: rtl/player_ctrl_key_arbiter.sv
// Turns raw left/right key levels into exclusive move requests: last-pressed key
// wins, simultaneous presses cancel, and a crash masks only its own direction.
module key_arbiter
    import player_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic i_enable,
    input  logic i_leftKey,
    input  logic i_rightKey,
    input  logic i_leftCrash,
    input  logic i_rightCrash,
    output logic o_leftPress,
    output logic o_rightPress
);

    logic      r_left_q;
    logic      r_right_q;
    last_key_t r_last;
    logic      r_left_press;
    logic      r_right_press;

    logic      w_left_rise;
    logic      w_right_rise;
    last_key_t w_last_next;
    logic      w_left_want;
    logic      w_right_want;

    assign w_left_rise  = i_leftKey  & ~r_left_q;
    assign w_right_rise = i_rightKey & ~r_right_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_last_next = r_last;
        if (w_left_rise && w_right_rise)
            w_last_next = LAST_NONE;
        else if (w_left_rise)
            w_last_next = LAST_LEFT;
        else if (w_right_rise)
            w_last_next = LAST_RIGHT;
    end

    always_comb begin
        w_left_want  = i_leftKey  & ~i_rightKey;
        w_right_want = i_rightKey & ~i_leftKey;
        if (i_leftKey && i_rightKey) begin
            w_left_want  = (w_last_next == LAST_LEFT);
            w_right_want = (w_last_next == LAST_RIGHT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_left_q      <= 1'b0;
            r_right_q     <= 1'b0;
            r_last        <= LAST_NONE;
            r_left_press  <= 1'b0;
            r_right_press <= 1'b0;
        end else begin
            r_left_q      <= i_leftKey;
            r_right_q     <= i_rightKey;
            r_last        <= w_last_next;
            r_left_press  <= i_enable & w_left_want  & ~i_leftCrash;
            r_right_press <= i_enable & w_right_want & ~i_rightCrash;
        end
    end

    assign o_leftPress  = r_left_press;
    assign o_rightPress = r_right_press;

endmodule

// File: rtl/player_ctrl.sv
// Player life-cycle controller: lives, hit freeze, respawn pulse, immunity.
// Define PLAYER_CTRL_BLINK_EN to blink the character while immunity is running.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int LIVES_INIT    = DEF_LIVES_INIT,
    parameter int HIT_FRAMES    = DEF_HIT_FRAMES,
`ifdef PLAYER_CTRL_BLINK_EN
    parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
`endif
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
)(
    input  logic       clk,
    input  logic       resetN,
    input  logic       i_startOfFrame,
    input  logic       i_leftKey,
    input  logic       i_rightKey,
    input  logic       i_leftCrash,
    input  logic       i_rightCrash,
    input  logic       i_ballHit,
    input  logic       i_gameStart,
    output logic       o_leftPress,
    output logic       o_rightPress,
    output logic       o_moverResetN,
    output logic       o_charVisible,
    output logic [1:0] o_lives,
    output logic       o_gameOver
);

    localparam int IMM_W = $clog2(INVULN_FRAMES + 1);
    localparam int HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

    state_t           r_state;
    logic [1:0]       r_lives;
    logic [IMM_W-1:0] r_immune;
    logic [HIT_W-1:0] r_hit_cnt;
    logic             r_mover_rst_n;
    logic             r_game_over;
    logic             r_char_vis;

    logic             w_hit;
    logic             w_play_next;

    assign w_hit = (r_state == ST_PLAY) && i_ballHit && (r_immune == '0);

    // Presses are gated by the state being entered, so none leak into HIT.
    assign w_play_next = (r_state == ST_RESPAWN) || ((r_state == ST_PLAY) && !w_hit);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_lives       <= 2'd0;
            r_immune      <= '0;
            r_hit_cnt     <= '0;
            r_mover_rst_n <= 1'b1;
            r_game_over   <= 1'b0;
        end else begin
            r_mover_rst_n <= 1'b1;
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (i_gameStart) begin
                        r_state       <= ST_RESPAWN;
                        r_lives       <= 2'(LIVES_INIT);
                        r_game_over   <= 1'b0;
                        r_mover_rst_n <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_hit) begin
                        r_state   <= ST_HIT;
                        r_hit_cnt <= '0;
                        if (r_lives != 2'd0)
                            r_lives <= r_lives - 2'd1;
                    end else if (i_startOfFrame && r_immune != '0) begin
                        r_immune <= r_immune - IMM_W'(1);
                    end
                end
                ST_HIT: begin
                    if (i_startOfFrame) begin
                        if (r_hit_cnt == HIT_W'(HIT_FRAMES - 1)) begin
                            r_hit_cnt <= '0;
                            if (r_lives == 2'd0) begin
                                r_state     <= ST_GAME_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state       <= ST_RESPAWN;
                                r_mover_rst_n <= 1'b0;
                            end
                        end else begin
                            r_hit_cnt <= r_hit_cnt + HIT_W'(1);
                        end
                    end
                end
                ST_RESPAWN: begin
                    r_state  <= ST_PLAY;
                    r_immune <= IMM_W'(INVULN_FRAMES);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PLAYER_CTRL_BLINK_EN
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BLK_W-1:0] r_blink_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_char_vis  <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_state == ST_RESPAWN) begin
            r_char_vis  <= 1'b0;
            r_blink_cnt <= '0;
        end else if (r_state == ST_PLAY) begin
            if (r_immune == '0) begin
                r_char_vis <= 1'b1;
            end else if (i_startOfFrame) begin
                if (r_immune == IMM_W'(1)) begin
                    r_char_vis <= 1'b1;
                end else if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                    r_char_vis  <= ~r_char_vis;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                end
            end
        end else begin
            r_char_vis <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_char_vis <= 1'b1;
        else
            r_char_vis <= 1'b1;
    end
`endif

    key_arbiter u_key_arbiter (
        .clk          (clk),
        .resetN       (resetN),
        .i_enable     (w_play_next),
        .i_leftKey    (i_leftKey),
        .i_rightKey   (i_rightKey),
        .i_leftCrash  (i_leftCrash),
        .i_rightCrash (i_rightCrash),
        .o_leftPress  (o_leftPress),
        .o_rightPress (o_rightPress)
    );

    assign o_moverResetN = r_mover_rst_n;
    assign o_charVisible = r_char_vis;
    assign o_lives       = r_lives;
    assign o_gameOver    = r_game_over;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios plus random play,
// every cycle compared against a frame/timestamp-level reference model.
module tb_player_ctrl;
    import player_ctrl_pkg::*;

    localparam int LI  = DEF_LIVES_INIT;
    localparam int HF  = DEF_HIT_FRAMES;
    localparam int IVF = DEF_INVULN_FRAMES;
    localparam int BF  = DEF_BLINK_FRAMES;

    logic       clk;
    logic       resetN;
    logic       sof, lk, rk, lc, rc, bh, gs;
    logic       lp, rp, mrst, vis, go;
    logic [1:0] lives;

    player_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .i_startOfFrame (sof),
        .i_leftKey      (lk),
        .i_rightKey     (rk),
        .i_leftCrash    (lc),
        .i_rightCrash   (rc),
        .i_ballHit      (bh),
        .i_gameStart    (gs),
        .o_leftPress    (lp),
        .o_rightPress   (rp),
        .o_moverResetN  (mrst),
        .o_charVisible  (vis),
        .o_lives        (lives),
        .o_gameOver     (go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: game phases with countdowns, key priority by press timestamps.
    typedef enum {M_IDLE, M_PLAY, M_HIT, M_RESPAWN, M_OVER} mphase_t;
    mphase_t m_phase;
    int m_lives, m_immune, m_hit_left, m_frames, m_edge, t_l, t_r;
    bit p_l, p_r;
    bit e_lp, e_rp, e_mrst, e_vis, e_go;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_lives = 0; m_immune = 0; m_hit_left = 0; m_frames = 0;
        t_l = 0; t_r = 0; p_l = 0; p_r = 0;
        e_lp = 0; e_rp = 0; e_mrst = 1; e_vis = 1; e_go = 0;
    endtask

    task automatic model_step();
        mphase_t nxt;
        bit lw, rw;
        m_edge++;
        if (lk && !p_l) t_l = m_edge;
        if (rk && !p_r) t_r = m_edge;
        p_l = lk;
        p_r = rk;
        lw = lk && (!rk || t_l > t_r);
        rw = rk && (!lk || t_r > t_l);
        nxt = m_phase;
        e_mrst = 1;
        case (m_phase)
            M_IDLE, M_OVER: if (gs) begin
                nxt = M_RESPAWN; m_lives = LI; e_go = 0; e_mrst = 0;
            end
            M_PLAY: if (bh && m_immune == 0) begin
                nxt = M_HIT; m_hit_left = HF;
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            end else if (sof && m_immune > 0) begin
                m_immune--; m_frames++;
            end
            M_HIT: if (sof) begin
                m_hit_left--;
                if (m_hit_left == 0) begin
                    if (m_lives == 0) begin nxt = M_OVER; e_go = 1; end
                    else begin nxt = M_RESPAWN; e_mrst = 0; end
                end
            end
            M_RESPAWN: begin
                nxt = M_PLAY; m_immune = IVF; m_frames = 0;
            end
        endcase
        m_phase = nxt;
        e_lp = (nxt == M_PLAY) && lw && !lc;
        e_rp = (nxt == M_PLAY) && rw && !rc;
        e_vis = 1;
`ifdef PLAYER_CTRL_BLINK_EN
        if (m_phase == M_PLAY && m_immune > 0) e_vis = ((m_frames / BF) % 2) == 1;
`endif
    endtask

    initial begin
        m_edge = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) model_reset();
            else model_step();
        end
    end

    bit mon_en = 0;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("leftPress",   int'(lp),    int'(e_lp));
            check("rightPress",  int'(rp),    int'(e_rp));
            check("moverResetN", int'(mrst),  int'(e_mrst));
            check("charVisible", int'(vis),   int'(e_vis));
            check("gameOver",    int'(go),    int'(e_go));
            check("lives",       int'(lives), m_lives);
        end
    end

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sof = 1'b1;
            @(negedge clk);
            sof = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic play_and_hit();
        frame_pulses(IVF);
        bh = 1'b1;
        @(negedge clk);
        bh = 1'b0;
        frame_pulses(HF);
        @(negedge clk);
    endtask

    int exp_entry_vis;

    initial begin
        resetN = 1'b0;
        {sof, lk, rk, lc, rc, bh, gs} = '0;
`ifdef PLAYER_CTRL_BLINK_EN
        exp_entry_vis = 0;
`else
        exp_entry_vis = 1;
`endif
        repeat (3) @(negedge clk);
        check("rst_lives", int'(lives), 0);
        check("rst_mover", int'(mrst), 1);
        check("rst_vis", int'(vis), 1);
        check("rst_gameover", int'(go), 0);
        check("rst_presses", int'({lp, rp}), 0);
        #2 resetN = 1'b1;
        mon_en = 1;
        @(negedge clk);

        // Start: one-clk mover reset, lives loaded, then PLAY under immunity.
        gs = 1'b1;
        @(negedge clk);
        gs = 1'b0;
        check("start_mover_low", int'(mrst), 0);
        check("start_lives", int'(lives), LI);
        @(negedge clk);
        check("start_mover_high", int'(mrst), 1);
        check("blink_entry_vis", int'(vis), exp_entry_vis);

        // Last press wins, release falls back.
        rk = 1'b1;
        @(negedge clk);
        check("right_only", int'({lp, rp}), 1);
        repeat (9) @(negedge clk);
        lk = 1'b1;
        @(negedge clk);
        check("left_takes_over", int'({lp, rp}), 2);
        lk = 1'b0;
        @(negedge clk);
        check("right_after_release", int'({lp, rp}), 1);

        // Crash masks its own direction only.
        rc = 1'b1;
        @(negedge clk);
        check("right_crash_masked", int'({lp, rp}), 0);
        rc = 1'b0;
        @(negedge clk);
        check("right_crash_cleared", int'({lp, rp}), 1);
        rk = 1'b0;
        @(negedge clk);

        // Simultaneous press gives neither direction.
        lk = 1'b1; rk = 1'b1;
        @(negedge clk);
        check("simultaneous_press", int'({lp, rp}), 0);
        lk = 1'b0; rk = 1'b0;
        @(negedge clk);

        // Hit ignored during immunity.
        bh = 1'b1;
        repeat (2) @(negedge clk);
        bh = 1'b0;
        check("immune_hit_ignored", int'(lives), LI);
        frame_pulses(IVF);
        check("immunity_end_vis", int'(vis), 1);

        // Real hit: freeze, then respawn pulse after HF frames.
        rk = 1'b1;
        @(negedge clk);
        bh = 1'b1;
        @(negedge clk);
        bh = 1'b0;
        check("hit_lives", int'(lives), LI - 1);
        check("hit_presses_off", int'({lp, rp}), 0);
        frame_pulses(HF - 1);
        check("hit_frozen", int'({lp, rp, mrst}), 1);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        check("respawn_mover_low", int'(mrst), 0);
        @(negedge clk);
        check("respawn_mover_high", int'(mrst), 1);
        rk = 1'b0;

        // Remaining lives down to game over, then restart.
        repeat (LI - 1) play_and_hit();
        check("over_lives", int'(lives), 0);
        check("over_flag", int'(go), 1);
        gs = 1'b1;
        @(negedge clk);
        gs = 1'b0;
        check("restart_lives", int'(lives), LI);
        check("restart_mover_low", int'(mrst), 0);
        check("restart_flag", int'(go), 0);
        @(negedge clk);

        // Reset in the middle of a hit abandons it without a mover pulse.
        frame_pulses(IVF);
        bh = 1'b1;
        @(negedge clk);
        bh = 1'b0;
        frame_pulses(10);
        #2 resetN = 1'b0;
        @(negedge clk);
        check("midhit_rst_mover", int'(mrst), 1);
        check("midhit_rst_lives", int'(lives), 0);
        #2 resetN = 1'b1;

        // Random play against the model.
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            sof = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) lk = !lk;
            if ($urandom_range(0, 7) == 0) rk = !rk;
            if (!lk && !rk && $urandom_range(0, 5) == 0) begin lk = 1'b1; rk = 1'b1; end
            if ($urandom_range(0, 9) == 0) lc = !lc;
            if ($urandom_range(0, 9) == 0) rc = !rc;
            bh = ($urandom_range(0, 15) == 0);
            gs = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 2999) == 0) begin
                #2 resetN = 1'b0;
                #10 resetN = 1'b1;
            end
        end
        @(negedge clk);
        mon_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
